spike_stream_arbiter: RTL and testbench

SPIKE_STREAM_ARBITER -- requirements
Module: spike_stream_arbiter

---
 rtl/spike_stream_arbiter.sv | 52 +++++
 tb/tb_spike_stream_arbiter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/spike_stream_arbiter.sv
// spike_stream_arbiter: round-robin merge of spike requesters onto a one-beat AXI-Stream output
module spike_stream_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int SRC_W   = 2
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  enable,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ*18-1:0] req_data,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic [31:0]           m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [SRC_W-1:0]      m_axis_tsrc,
  output logic [31:0]           grant_count
);
  logic [SRC_W-1:0] rr_ptr;
  logic [SRC_W-1:0] win;
  logic             load;
  // first valid requester at or above rr_ptr, wrapping; descending scan lets the closest one win
  always_comb begin
    win = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      int idx;
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (req_valid[idx]) win = SRC_W'(idx);
    end
  end
  assign load         = !areset && enable && (!m_axis_tvalid || m_axis_tready) && (req_valid != '0);
  assign req_ready    = load ? NUM_REQ'(1) << win : '0;
  assign m_axis_tlast = m_axis_tvalid;
  // output beat register, round-robin pointer and grant counter
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tsrc   <= '0;
      rr_ptr        <= '0;
      grant_count   <= '0;
    end else if (load) begin
      m_axis_tvalid <= 1'b1;
      m_axis_tdata  <= {14'd0, req_data[18*int'(win) +: 18]};
      m_axis_tsrc   <= win;
      rr_ptr        <= (int'(win) == NUM_REQ - 1) ? '0 : win + 1'b1;
      grant_count   <= grant_count + 32'd1;
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_spike_stream_arbiter.sv
// tb_spike_stream_arbiter: directed stimulus with a queue scoreboard checked by a stream monitor
module tb_spike_stream_arbiter;
  localparam int N  = 4;
  localparam int SW = 2;
  logic            aclk = 1'b0;
  logic            areset = 1'b1;
  logic            enable = 1'b0;
  logic            m_axis_tready = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [N*18-1:0] req_data;
  logic [31:0]     m_axis_tdata;
  logic [31:0]     grant_count;
  logic            m_axis_tvalid;
  logic            m_axis_tlast;
  logic [SW-1:0]   m_axis_tsrc;
  int              checks = 0;
  int              passed = 0;
  logic [33:0]     sbq[$];
  logic [33:0]     mon_e;

  spike_stream_arbiter #(.NUM_REQ(N), .SRC_W(SW)) dut (
    .aclk(aclk), .areset(areset), .enable(enable),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .m_axis_tsrc(m_axis_tsrc), .grant_count(grant_count)
  );

  always #10 aclk = ~aclk;

  function automatic logic [17:0] pkt(int i);
    return (i == 2) ? {8'd50, 10'd1} : {8'(10 + i * 7), 10'(100 + i * 3)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic exp_beat(input int s);
    sbq.push_back({SW'(s), 14'd0, pkt(s)});
  endtask

  task automatic step;
    @(posedge aclk);
    #1;
  endtask

  always @(negedge aclk) begin
    if (!areset && m_axis_tvalid && m_axis_tready) begin
      if (sbq.size() == 0) chk("unexpected_beat", 32'(sbq.size()), 32'd1);
      else begin
        mon_e = sbq.pop_front();
        chk("beat_tdata", m_axis_tdata, mon_e[31:0]);
        chk("beat_tsrc", 32'(m_axis_tsrc), 32'(mon_e[33:32]));
        chk("beat_tlast", 32'(m_axis_tlast), 32'd1);
      end
    end
  end

  initial begin
    for (int i = 0; i < N; i++) req_data[i*18 +: 18] = pkt(i);
    enable = 1'b1;
    req_valid = '1;
    m_axis_tready = 1'b1;
    #2;
    chk("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("rst_tdata", m_axis_tdata, 32'd0);
    chk("rst_tsrc", 32'(m_axis_tsrc), 32'd0);
    chk("rst_count", grant_count, 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    // single requester 2
    @(negedge aclk);
    areset = 1'b0;
    req_valid = 4'b0100;
    #1;
    chk("single_ready", 32'(req_ready), 32'h4);
    exp_beat(2);
    step;
    req_valid = '0;
    #1;
    chk("single_tdata", m_axis_tdata, 32'h0000C801);
    chk("single_tsrc", 32'(m_axis_tsrc), 32'd2);
    chk("single_tlast", 32'(m_axis_tlast), 32'd1);
    chk("single_count", grant_count, 32'd1);
    chk("single_ready_off", 32'(req_ready), 32'd0);
    step;
    areset = 1'b1;
    #1;
    areset = 1'b0;
    // all valid, back-to-back round robin from pointer 0
    req_valid = '1;
    #1;
    for (int i = 0; i < 8; i++) begin
      chk("rr_ready", 32'(req_ready), 32'(1 << (i % 4)));
      exp_beat(i % 4);
      step;
    end
    req_valid = '0;
    #1;
    chk("rr_count", grant_count, 32'd8);
    step;
    // backpressure holds the beat
    m_axis_tready = 1'b0;
    req_valid = 4'b0010;
    #1;
    chk("bp_first_ready", 32'(req_ready), 32'h2);
    exp_beat(1);
    step;
    req_valid = '1;
    #1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_ready", 32'(req_ready), 32'd0);
      chk("bp_tdata", m_axis_tdata, {14'd0, pkt(1)});
      chk("bp_tsrc", 32'(m_axis_tsrc), 32'd1);
      step;
    end
    m_axis_tready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(req_ready), 32'h4);
    exp_beat(2);
    step;
    req_valid = '0;
    #1;
    step;
    // enable drop with a pending beat
    m_axis_tready = 1'b0;
    req_valid = 4'b1000;
    #1;
    chk("en_first_ready", 32'(req_ready), 32'h8);
    exp_beat(3);
    step;
    enable = 1'b0;
    req_valid = '1;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("en_off_ready", 32'(req_ready), 32'd0);
      chk("en_off_tvalid", 32'(m_axis_tvalid), 32'd1);
      step;
    end
    m_axis_tready = 1'b1;
    #1;
    chk("en_off_drain_ready", 32'(req_ready), 32'd0);
    step;
    chk("en_off_tvalid_clr", 32'(m_axis_tvalid), 32'd0);
    chk("en_off_idle_ready", 32'(req_ready), 32'd0);
    enable = 1'b1;
    #1;
    chk("en_on_ready", 32'(req_ready), 32'h1);
    exp_beat(0);
    step;
    m_axis_tready = 1'b0;
    req_valid = '0;
    #1;
    // reset with a beat in flight
    chk("mid_tvalid", 32'(m_axis_tvalid), 32'd1);
    areset = 1'b1;
    #1;
    chk("ar_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("ar_count", grant_count, 32'd0);
    chk("ar_tdata", m_axis_tdata, 32'd0);
    req_valid = '1;
    #1;
    chk("ar_ready", 32'(req_ready), 32'd0);
    sbq.delete();
    areset = 1'b0;
    m_axis_tready = 1'b1;
    #1;
    chk("ar_first_ready", 32'(req_ready), 32'h1);
    exp_beat(0);
    step;
    req_valid = '0;
    #1;
    chk("ar_count_after", grant_count, 32'd1);
    step;
    // counter wrap
    force dut.grant_count = 32'hFFFFFFFF;
    #1;
    release dut.grant_count;
    #1;
    chk("wrap_preload", grant_count, 32'hFFFFFFFF);
    req_valid = 4'b0010;
    #1;
    chk("wrap_ready", 32'(req_ready), 32'h2);
    exp_beat(1);
    step;
    req_valid = '0;
    #1;
    chk("wrap_count", grant_count, 32'd0);
    step;
    step;
    chk("sb_drained", 32'(sbq.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
